// File: rtl/fea_desc_serializer.sv
// fea_desc_serializer: queues {col,row,descriptor} records on feature_flag and streams each MSB-first as bytes.
// Build option: define DESC_SER_HEADER_EN to precede every record with the sync byte 8'hA5.
module fea_desc_serializer #(
  parameter int COOR_W     = 10,
  parameter int DESC_W     = 128,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        feature_flag,
  input  logic [2*COOR_W+DESC_W-1:0]  des_coor,
  output logic [7:0]                  byte_out,
  output logic                        byte_valid,
  input  logic                        byte_ready,
  output logic                        byte_last,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic [15:0]                 drop_cnt,
  input  logic                        clr_status,
  output logic                        busy
);

  localparam int REC_W  = 2*COOR_W + DESC_W;
  localparam int NBYTES = (REC_W + 7) / 8;
  localparam int PAD_W  = NBYTES * 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int IDX_W  = $clog2(NBYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

`ifdef DESC_SER_HEADER_EN
  typedef enum logic [1:0] {IDLE, HDR, SEND} state_t;
  localparam state_t FIRST = HDR;
`else
  typedef enum logic {IDLE, SEND} state_t;
  localparam state_t FIRST = SEND;
`endif

  logic [REC_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]   wrPtr_q, rdPtr_q;
  logic [PAD_W-1:0] shiftReg_q, shiftReg_d, headRec;
  logic [IDX_W-1:0] byteIdx_q, byteIdx_d;
  state_t           state_q, state_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      dropCnt_q, dropCnt_d;
  logic             fifoEmpty, fifoFull, doWrite, doDrop, doPop, lastByte;

  // Pointers carry one extra wrap bit so their difference is the occupancy.
  assign fifo_level = wrPtr_q - rdPtr_q;
  assign fifoEmpty  = (fifo_level == '0);
  assign fifoFull   = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign doWrite    = feature_flag & ~fifoFull;
  assign doDrop     = feature_flag & fifoFull;
  assign headRec    = PAD_W'(mem_q[rdPtr_q[PTR_W-1:0]]);
  assign lastByte   = (state_q == SEND) && (byteIdx_q == LAST_IDX);

  assign overflow = overflow_q;
  assign drop_cnt = dropCnt_q;
  assign busy     = (state_q != IDLE) | ~fifoEmpty;

  always_ff @(posedge clk) begin
    if (doWrite) mem_q[wrPtr_q[PTR_W-1:0]] <= des_coor;
  end

  // Output bytes come straight from the shift register so they hold still while the sink stalls.
  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    byteIdx_d  = byteIdx_q;
    doPop      = 1'b0;
    byte_out   = 8'h00;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          doPop      = 1'b1;
          shiftReg_d = headRec;
          byteIdx_d  = '0;
          state_d    = FIRST;
        end
      end
`ifdef DESC_SER_HEADER_EN
      HDR: begin
        byte_out   = 8'hA5;
        byte_valid = 1'b1;
        if (byte_ready) state_d = SEND;
      end
`endif
      SEND: begin
        byte_out   = shiftReg_q[PAD_W-1 -: 8];
        byte_valid = 1'b1;
        byte_last  = lastByte;
        if (byte_ready) begin
          if (lastByte) begin
            if (!fifoEmpty) begin
              doPop      = 1'b1;
              shiftReg_d = headRec;
              byteIdx_d  = '0;
              state_d    = FIRST;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shiftReg_d = shiftReg_q << 8;
            byteIdx_d  = byteIdx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A drop coinciding with a clear is still recorded as the first drop after it.
  always_comb begin
    overflow_d = overflow_q;
    dropCnt_d  = dropCnt_q;
    if (clr_status) begin
      overflow_d = doDrop;
      dropCnt_d  = doDrop ? 16'd1 : 16'd0;
    end else if (doDrop) begin
      overflow_d = 1'b1;
      if (dropCnt_q != 16'hFFFF) dropCnt_d = dropCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      byteIdx_q  <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
      dropCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      byteIdx_q  <= byteIdx_d;
      overflow_q <= overflow_d;
      dropCnt_q  <= dropCnt_d;
      if (doWrite) wrPtr_q <= wrPtr_q + LVL_W'(1);
      if (doPop)   rdPtr_q <= rdPtr_q + LVL_W'(1);
    end
  end

endmodule

// File: tb/tb_fea_desc_serializer.sv
// tb_fea_desc_serializer: directed bench for fea_desc_serializer; follows DESC_SER_HEADER_EN like the design.
module tb_fea_desc_serializer;

  localparam int REC_W = 148;
`ifdef DESC_SER_HEADER_EN
  localparam int HDR  = 1;
`else
  localparam int HDR  = 0;
`endif
  localparam int RECB = 19 + HDR;

  logic             clk, rst, feature_flag, byte_ready, clr_status;
  logic [REC_W-1:0] des_coor;
  logic [7:0]       byte_out;
  logic             byte_valid, byte_last, overflow, busy;
  logic [4:0]       fifo_level;
  logic [15:0]      drop_cnt;

  int assertCount = 0;
  int failCount   = 0;
  logic [REC_W-1:0] expQ[$];

  fea_desc_serializer dut (
    .clk(clk), .rst(rst), .feature_flag(feature_flag), .des_coor(des_coor),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_last(byte_last), .fifo_level(fifo_level), .overflow(overflow),
    .drop_cnt(drop_cnt), .clr_status(clr_status), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected byte j of the transmitted stream for a record, including the optional sync byte.
  function automatic logic [7:0] expStream(input logic [REC_W-1:0] rec, input int j);
    logic [151:0] padded;
    int k;
    padded = {4'b0, rec};
    k = j - HDR;
    if (k < 0) return 8'hA5;
    return padded[151-8*k -: 8];
  endfunction

  function automatic logic [REC_W-1:0] mkRec(input int i);
    return {10'(i*37 + 3), 10'(1023 - i), {4{32'hC0DE0000 + 32'(i)}}};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Drives one cycle of inputs starting at a falling edge; the pulse-type inputs drop afterwards.
  task automatic applyStimulus(input logic flag, input logic [REC_W-1:0] rec, input logic clr);
    feature_flag = flag;
    des_coor     = rec;
    clr_status   = clr;
    @(negedge clk);
    feature_flag = 1'b0;
    clr_status   = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_byte_out"},   byte_out,   0);
    checkOutput({tag, "_byte_valid"}, byte_valid, 0);
    checkOutput({tag, "_byte_last"},  byte_last,  0);
    checkOutput({tag, "_fifo_level"}, fifo_level, 0);
    checkOutput({tag, "_overflow"},   overflow,   0);
    checkOutput({tag, "_drop_cnt"},   drop_cnt,   0);
    checkOutput({tag, "_busy"},       busy,       0);
  endtask

  // Consumes nrec records from expQ; cycles counts from the first valid byte on.
  task automatic drainRecords(input int nrec, input bit toggle, input bit noGap, output int cycles);
    int j, done, budget;
    bit started;
    logic [REC_W-1:0] rec;
    j = 0; done = 0; cycles = 0; budget = 0; started = 0;
    while (done < nrec && budget < 2000) begin
      rec = expQ[0];
      if (byte_valid) started = 1;
      byte_ready = (toggle && started) ? ((cycles % 2) == 0) : 1'b1;
      if (byte_valid) begin
        checkOutput("stream_byte", byte_out, expStream(rec, j));
        checkOutput("stream_last", byte_last, (j == RECB-1));
        if (byte_ready) begin
          if (j == RECB-1) begin
            j = 0;
            done++;
            void'(expQ.pop_front());
          end else begin
            j++;
          end
        end
      end else if (started && noGap) begin
        checkOutput("stream_gap", byte_valid, 1);
      end
      @(negedge clk);
      budget++;
      if (started) cycles++;
    end
    if (done < nrec) checkOutput("drain_timeout", done, nrec);
  endtask

  logic [REC_W-1:0] recT1;
  logic [7:0]       t1Bytes [19];
  int               cycles;

  initial begin
    clk = 0; rst = 1; feature_flag = 0; des_coor = '0; byte_ready = 0; clr_status = 0;
    recT1   = {10'h3FF, 10'h001, 128'h0123456789ABCDEF0123456789ABCDEF};
    t1Bytes = '{8'h0F, 8'hFC, 8'h01, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD,
                8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    repeat (2) @(negedge clk);
    checkIdleOutputs("reset_hold");
    rst = 0;
    @(negedge clk);
    checkIdleOutputs("reset_release");

    // T1: single record, sink always ready, hand-computed byte table
    byte_ready = 1;
    applyStimulus(1, recT1, 0);
    checkOutput("t1_cycle1_valid", byte_valid, 0);
    checkOutput("t1_cycle1_level", fifo_level, 1);
    checkOutput("t1_cycle1_busy",  busy, 1);
    @(negedge clk);
    for (int j = 0; j < RECB; j++) begin
      checkOutput("t1_valid", byte_valid, 1);
      checkOutput("t1_byte",  byte_out, (j < HDR) ? 8'hA5 : t1Bytes[j-HDR]);
      checkOutput("t1_last",  byte_last, (j == RECB-1));
      @(negedge clk);
    end
    checkOutput("t1_end_valid", byte_valid, 0);
    checkOutput("t1_end_busy",  busy, 0);

    // T2: same record with the sink ready every other cycle
    expQ.push_back(recT1);
    fork
      applyStimulus(1, recT1, 0);
      drainRecords(1, 1, 0, cycles);
    join
    checkOutput("t2_cycles", cycles, 2*RECB-1);
    checkOutput("t2_end_valid", byte_valid, 0);

    // T4: three back-to-back records stream with no bubble
    for (int i = 0; i < 3; i++) expQ.push_back(mkRec(100 + i));
    fork
      begin
        for (int i = 0; i < 3; i++) applyStimulus(1, mkRec(100 + i), 0);
      end
      drainRecords(3, 0, 1, cycles);
    join
    checkOutput("t4_cycles", cycles, 3*RECB);
    checkOutput("t4_end_busy", busy, 0);

    // T3: sink stalled, 19 pulses: one in the shift register, 16 queued, 2 dropped
    byte_ready = 0;
    for (int i = 0; i < 19; i++) begin
      applyStimulus(1, mkRec(i), 0);
      if (i < 17) expQ.push_back(mkRec(i));
    end
    checkOutput("t3_level",    fifo_level, 16);
    checkOutput("t3_overflow", overflow, 1);
    checkOutput("t3_drop_cnt", drop_cnt, 2);
    checkOutput("t3_valid",    byte_valid, 1);
    checkOutput("t3_byte0",    byte_out, expStream(mkRec(0), 0));
    drainRecords(17, 0, 1, cycles);
    checkOutput("t3_cycles", cycles, 17*RECB);
    checkOutput("t3_end_level", fifo_level, 0);
    checkOutput("t3_sticky_overflow", overflow, 1);

    // Status clear, then a clear coinciding with a drop
    applyStimulus(0, '0, 1);
    checkOutput("clr_overflow", overflow, 0);
    checkOutput("clr_drop_cnt", drop_cnt, 0);
    byte_ready = 0;
    for (int i = 0; i < 17; i++) applyStimulus(1, mkRec(200 + i), 0);
    checkOutput("clr_full_level", fifo_level, 16);
    checkOutput("clr_no_drop_yet", drop_cnt, 0);
    applyStimulus(1, mkRec(300), 1);
    checkOutput("clr_drop_overflow", overflow, 1);
    checkOutput("clr_drop_cnt", drop_cnt, 1);

    // T5: async reset in the middle of a record with two more queued
    #2 rst = 1;
    #1 checkIdleOutputs("full_async_reset");
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1, mkRec(400 + i), 0);
    byte_ready = 1;
    repeat (7) @(negedge clk);
    checkOutput("t5_byte7", byte_out, expStream(mkRec(400), 7));
    checkOutput("t5_level", fifo_level, 2);
    #2 rst = 1;
    #1 checkIdleOutputs("t5_async_reset");
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t5_quiet_valid", byte_valid, 0);
      checkOutput("t5_quiet_busy",  busy, 0);
    end
    expQ.delete();
    expQ.push_back(mkRec(500));
    fork
      applyStimulus(1, mkRec(500), 0);
      drainRecords(1, 0, 1, cycles);
    join
    checkOutput("t5_after_cycles", cycles, RECB);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
